sdram_bank_scheduler: RTL and testbench

//  Open-page command scheduler between the port arbiter and the SDRAM command/IO stage.
//  - Takes one decoded request at a time (bank/row/column from the address-mapping stage).
//  - Tracks the open row of every bank.
//  - Sequences PRE/ACT/RD/WR under programmable timing and interleaves refresh (PREA+REF).
//  - Issues one registered command per cycle; NOP otherwise.

---
 rtl/sdram_bank_scheduler.sv | 170 +++++++++++++++++
 tb/tb_sdram_bank_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bank_scheduler.sv
// sdram_bank_scheduler: open-page PRE/ACT/RD/WR sequencer with refresh interleave.
// Handshake: req_valid_i holds bank/row/col/we stable until req_ready_o. req_ready_o
// is combinational and high only in the cycle that decides the request's RD/WR, so
// the request is consumed on that clock edge. ref_req_i is a level held until the
// one-cycle ref_ack_o pulse, which coincides with REF on cmd_o.
module sdram_bank_scheduler #(
   parameter int MAX_CSIZE = 11,
   parameter int MAX_RSIZE = 13,
   parameter int BA_SIZE   = 2,
   parameter int TW        = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_we_i,
   input  logic [BA_SIZE-1:0]       req_bank_i,
   input  logic [MAX_RSIZE-1:0]     req_row_i,
   input  logic [MAX_CSIZE-1:0]     req_col_i,
   input  logic                     ref_req_i,
   output logic                     ref_ack_o,
   output logic [2:0]               cmd_o,
   output logic [BA_SIZE-1:0]       cmd_ba_o,
   output logic [MAX_RSIZE-1:0]     cmd_addr_o,
   output logic [(2**BA_SIZE)-1:0]  bank_open_o,
   input  logic [TW-1:0]            trp_i,
   input  logic [TW-1:0]            trcd_i,
   input  logic [TW-1:0]            tras_i,
   input  logic [TW-1:0]            twr_i,
   input  logic [TW-1:0]            trfc_i,
   output logic [1:0]               fsm_state_o
);

   localparam int NBANKS = 2**BA_SIZE;
   localparam int A10    = 10;

   localparam logic [2:0] CMD_NOP  = 3'b000;
   localparam logic [2:0] CMD_ACT  = 3'b001;
   localparam logic [2:0] CMD_RD   = 3'b010;
   localparam logic [2:0] CMD_WR   = 3'b011;
   localparam logic [2:0] CMD_PRE  = 3'b100;
   localparam logic [2:0] CMD_PREA = 3'b101;
   localparam logic [2:0] CMD_REF  = 3'b110;

   typedef enum logic [1:0] {IDLE, TWAIT, REF_PRE, REF_WAIT} state_t;

   state_t                state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [TW-1:0]         ras_q;
   logic [NBANKS-1:0]     open_q, open_d;
   logic [MAX_RSIZE-1:0]  row_q [NBANKS];
   logic                  ref_q;
   logic                  ref_pend;
   logic                  ras_ok;
   logic                  row_we;
   logic                  ras_restart;
   logic [2:0]            cmd_d;
   logic [BA_SIZE-1:0]    ba_d;
   logic [MAX_RSIZE-1:0]  addr_d;
   logic                  ack_d;

   // Timer reload: the next decision is allowed max(t,1) cycles after this one.
   function automatic logic [TW-1:0] span(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - TW'(1);
   endfunction

   // A refresh request counts once it has been held for a full cycle, so a request
   // rising alongside a RD/WR decision lets that access complete first.
   assign ref_pend    = ref_req_i & ref_q;
   assign ras_ok      = (ras_q >= tras_i);
   assign bank_open_o = open_q;
   assign fsm_state_o = state_q;

   // Next-state and command decision; IDLE/TWAIT/REF_WAIT all decide once the timer is 0.
   always_comb begin
      state_d     = state_q;
      timer_d     = (timer_q == '0) ? '0 : timer_q - TW'(1);
      open_d      = open_q;
      cmd_d       = CMD_NOP;
      ba_d        = '0;
      addr_d      = '0;
      ack_d       = 1'b0;
      req_ready_o = 1'b0;
      row_we      = 1'b0;
      ras_restart = 1'b0;
      if (state_q == REF_PRE) begin
         if (timer_q == '0) begin
            cmd_d   = CMD_REF;
            ack_d   = 1'b1;
            timer_d = span(trfc_i);
            state_d = REF_WAIT;
         end
      end else if (timer_q == '0) begin
         state_d = IDLE;
         if (ref_pend) begin
            if (|open_q) begin
               if (ras_ok) begin
                  cmd_d       = CMD_PREA;
                  addr_d[A10] = 1'b1;
                  open_d      = '0;
                  timer_d     = span(trp_i);
                  state_d     = REF_PRE;
               end
            end else begin
               cmd_d   = CMD_REF;
               ack_d   = 1'b1;
               timer_d = span(trfc_i);
               state_d = REF_WAIT;
            end
         end else if (req_valid_i) begin
            if (open_q[req_bank_i] && (row_q[req_bank_i] == req_row_i)) begin
               cmd_d       = req_we_i ? CMD_WR : CMD_RD;
               ba_d        = req_bank_i;
               addr_d      = MAX_RSIZE'(req_col_i);
               addr_d[A10] = 1'b0;
               req_ready_o = 1'b1;
               timer_d     = req_we_i ? span(twr_i) : '0;
               state_d     = TWAIT;
            end else if (!open_q[req_bank_i]) begin
               cmd_d              = CMD_ACT;
               ba_d               = req_bank_i;
               addr_d             = req_row_i;
               open_d[req_bank_i] = 1'b1;
               row_we             = 1'b1;
               ras_restart        = 1'b1;
               timer_d            = span(trcd_i);
               state_d            = TWAIT;
            end else if (ras_ok) begin
               cmd_d              = CMD_PRE;
               ba_d               = req_bank_i;
               open_d[req_bank_i] = 1'b0;
               timer_d            = span(trp_i);
               state_d            = TWAIT;
            end
         end
      end
   end

   // State, timers, open flags and the registered command outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         ras_q      <= '0;
         open_q     <= '0;
         ref_q      <= 1'b0;
         cmd_o      <= CMD_NOP;
         cmd_ba_o   <= '0;
         cmd_addr_o <= '0;
         ref_ack_o  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         open_q     <= open_d;
         ref_q      <= ref_req_i;
         cmd_o      <= cmd_d;
         cmd_ba_o   <= ba_d;
         cmd_addr_o <= addr_d;
         ref_ack_o  <= ack_d;
         if (ras_restart) ras_q <= TW'(1);
         else if (ras_q != '1) ras_q <= ras_q + TW'(1);
      end
   end

   // Open-row table; only meaningful where the open flag is set, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (row_we) row_q[req_bank_i] <= req_row_i;
   end

endmodule

// File: tb/tb_sdram_bank_scheduler.sv
// Bench for sdram_bank_scheduler: request table plus hand-written refresh/reset sequences.
module tb_sdram_bank_scheduler;
   localparam int W = 27;   // {is_min, gap[7:0], cmd[2:0], ba[1:0], addr[12:0]}
   localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3;
   localparam logic [2:0] C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6;

   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        req_valid_i = 1'b0, req_we_i = 1'b0, ref_req_i = 1'b0;
   logic [1:0]  req_bank_i = '0;
   logic [12:0] req_row_i = '0;
   logic [10:0] req_col_i = '0;
   logic [3:0]  trp_i = 4'd2, trcd_i = 4'd3, tras_i = 4'd6, twr_i = 4'd2, trfc_i = 4'd7;
   logic        req_ready_o, ref_ack_o;
   logic [2:0]  cmd_o;
   logic [1:0]  cmd_ba_o, fsm_state_o;
   logic [12:0] cmd_addr_o;
   logic [3:0]  bank_open_o;

   int n_cmp = 0, n_fail = 0, since_cmd = 0, ready_cnt = 0;
   logic [W-1:0] exp_q[$];

   typedef struct packed {
      logic we; logic [1:0] bank; logic [12:0] row; logic [10:0] col; logic [1:0] n;
      logic [2:0] c0; logic [1:0] b0; logic [12:0] a0; logic [7:0] g0;
      logic [2:0] c1; logic [1:0] b1; logic [12:0] a1; logic [7:0] g1;
      logic [2:0] c2; logic [1:0] b2; logic [12:0] a2; logic [7:0] g2;
   } vec_t;
   vec_t vt [9];

   sdram_bank_scheduler dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_bank_i(req_bank_i), .req_row_i(req_row_i), .req_col_i(req_col_i),
      .ref_req_i(ref_req_i), .ref_ack_o(ref_ack_o), .cmd_o(cmd_o), .cmd_ba_o(cmd_ba_o),
      .cmd_addr_o(cmd_addr_o), .bank_open_o(bank_open_o), .trp_i(trp_i), .trcd_i(trcd_i),
      .tras_i(tras_i), .twr_i(twr_i), .trfc_i(trfc_i), .fsm_state_o(fsm_state_o)
   );

   // Clock
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_min(input string name, input int act, input int lo);
      n_cmp++;
      if (act < lo) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected >= %0d (t=%0t)", name, act, lo, $time);
      end
   endtask

   task automatic push_exp(input logic is_min, input logic [7:0] gap, input logic [2:0] c,
                           input logic [1:0] b, input logic [12:0] a);
      exp_q.push_back({is_min, gap, c, b, a});
   endtask

   // Scoreboard: every non-NOP command pops one expected entry; gap is cycles since the previous command.
   always @(negedge clk_i) begin
      logic [W-1:0] e;
      if (req_ready_o) ready_cnt++;
      since_cmd++;
      if (cmd_o != C_NOP) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_cmd: got cmd %0d ba %0d addr 0x%0h, expected no command",
                     cmd_o, cmd_ba_o, cmd_addr_o);
         end else begin
            e = exp_q.pop_front();
            check("cmd", int'(cmd_o), int'(e[17:15]));
            check("cmd_ba", int'(cmd_ba_o), int'(e[14:13]));
            check("cmd_addr", int'(cmd_addr_o), int'(e[12:0]));
            check("ref_ack", int'(ref_ack_o), int'(e[17:15] == C_REF));
            if (e[25:18] != 8'd0) begin
               if (e[26]) check_min("gap_min", since_cmd, int'(e[25:18]));
               else       check("gap", since_cmd, int'(e[25:18]));
            end
         end
         since_cmd = 0;
      end else if (ref_ack_o) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ack_without_ref: got ref_ack_o 1 with NOP, expected 0");
      end
   end

   // Present one request and hold it until req_ready_o consumes it.
   task automatic drive_req(input logic we, input logic [1:0] b, input logic [12:0] r,
                            input logic [10:0] c);
      int n;
      req_we_i = we; req_bank_i = b; req_row_i = r; req_col_i = c; req_valid_i = 1'b1;
      n = 0;
      #1;
      while (!req_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (!req_ready_o) check("req_ready_timeout", 0, 1);
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      check("drain_left", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge clk_i);
   endtask

   task automatic wait_ack();
      int n;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!ref_ack_o && n < 100);
      check("ref_ack_seen", int'(ref_ack_o), 1);
   endtask

   task automatic wait_cmd(input logic [2:0] c);
      int n;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (cmd_o != c && n < 100);
      check("cmd_seen", int'(cmd_o), int'(c));
   endtask

   task automatic ref_on_pre();
      wait_cmd(C_PRE);
      ref_req_i = 1'b1;
      wait_ack();
      ref_req_i = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_cmd"}, int'(cmd_o), 0);
      check({tag, "_ba"}, int'(cmd_ba_o), 0);
      check({tag, "_addr"}, int'(cmd_addr_o), 0);
      check({tag, "_ack"}, int'(ref_ack_o), 0);
      check({tag, "_open"}, int'(bank_open_o), 0);
      check({tag, "_ready"}, int'(req_ready_o), 0);
      check({tag, "_state"}, int'(fsm_state_o), 0);
   endtask

   initial begin
      // Reset
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check_reset("reset");

      // Request table: trp=2 trcd=3 tras=6 twr=2; gaps counted from the previous command.
      vt[0] = '{1'b0, 2'd1, 13'h123, 11'h045, 2'd2, C_ACT, 2'd1, 13'h123, 8'd0,
                C_RD, 2'd1, 13'h045, 8'd3, C_NOP, 2'd0, 13'h0, 8'd0};
      vt[1] = '{1'b0, 2'd1, 13'h123, 11'h046, 2'd1, C_RD, 2'd1, 13'h046, 8'd1,
                C_NOP, 2'd0, 13'h0, 8'd0, C_NOP, 2'd0, 13'h0, 8'd0};
      vt[2] = '{1'b1, 2'd1, 13'h123, 11'h047, 2'd1, C_WR, 2'd1, 13'h047, 8'd1,
                C_NOP, 2'd0, 13'h0, 8'd0, C_NOP, 2'd0, 13'h0, 8'd0};
      vt[3] = '{1'b1, 2'd1, 13'h123, 11'h048, 2'd1, C_WR, 2'd1, 13'h048, 8'd2,
                C_NOP, 2'd0, 13'h0, 8'd0, C_NOP, 2'd0, 13'h0, 8'd0};
      vt[4] = '{1'b0, 2'd1, 13'h200, 11'h010, 2'd3, C_PRE, 2'd1, 13'h0, 8'd2,
                C_ACT, 2'd1, 13'h200, 8'd2, C_RD, 2'd1, 13'h010, 8'd3};
      vt[5] = '{1'b0, 2'd3, 13'h005, 11'h001, 2'd2, C_ACT, 2'd3, 13'h005, 8'd1,
                C_RD, 2'd3, 13'h001, 8'd3, C_NOP, 2'd0, 13'h0, 8'd0};
      vt[6] = '{1'b0, 2'd3, 13'h006, 11'h002, 2'd3, C_PRE, 2'd3, 13'h0, 8'd3,
                C_ACT, 2'd3, 13'h006, 8'd2, C_RD, 2'd3, 13'h002, 8'd3};
      vt[7] = '{1'b1, 2'd1, 13'h200, 11'h7FF, 2'd1, C_WR, 2'd1, 13'h3FF, 8'd1,
                C_NOP, 2'd0, 13'h0, 8'd0, C_NOP, 2'd0, 13'h0, 8'd0};
      vt[8] = '{1'b0, 2'd0, 13'h1FFF, 11'h000, 2'd2, C_ACT, 2'd0, 13'h1FFF, 8'd2,
                C_RD, 2'd0, 13'h000, 8'd3, C_NOP, 2'd0, 13'h0, 8'd0};
      for (int i = 0; i < 9; i++) begin
         if (vt[i].n > 2'd0) push_exp(1'b0, vt[i].g0, vt[i].c0, vt[i].b0, vt[i].a0);
         if (vt[i].n > 2'd1) push_exp(1'b0, vt[i].g1, vt[i].c1, vt[i].b1, vt[i].a1);
         if (vt[i].n > 2'd2) push_exp(1'b0, vt[i].g2, vt[i].c2, vt[i].b2, vt[i].a2);
         drive_req(vt[i].we, vt[i].bank, vt[i].row, vt[i].col);
      end
      drain();
      check("open_after_table", int'(bank_open_o), 'hB);

      // Reset clears the open table; zero trcd behaves as 1; then refresh with banks 0 and 2 open.
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check_reset("reset2");
      trcd_i = 4'd0;
      push_exp(1'b0, 8'd0, C_ACT, 2'd0, 13'h010);
      push_exp(1'b0, 8'd1, C_RD, 2'd0, 13'h003);
      drive_req(1'b0, 2'd0, 13'h010, 11'h003);
      trcd_i = 4'd3;
      push_exp(1'b0, 8'd1, C_ACT, 2'd2, 13'h020);
      push_exp(1'b0, 8'd3, C_RD, 2'd2, 13'h004);
      drive_req(1'b0, 2'd2, 13'h020, 11'h004);
      drain();
      check("open_before_ref", int'(bank_open_o), 'h5);
      push_exp(1'b0, 8'd0, C_PREA, 2'd0, 13'h400);
      push_exp(1'b0, 8'd2, C_REF, 2'd0, 13'h000);
      ref_req_i = 1'b1;
      wait_ack();
      ref_req_i = 1'b0;
      check("open_after_ref", int'(bank_open_o), 0);
      check("ready_during_ref", int'(req_ready_o), 0);
      push_exp(1'b1, 8'd7, C_ACT, 2'd2, 13'h020);
      push_exp(1'b0, 8'd3, C_RD, 2'd2, 13'h005);
      drive_req(1'b0, 2'd2, 13'h020, 11'h005);
      drain();

      // Refresh raised during the precharge wait of a row miss.
      push_exp(1'b0, 8'd0, C_PRE, 2'd2, 13'h000);
      push_exp(1'b1, 8'd2, C_REF, 2'd0, 13'h000);
      push_exp(1'b1, 8'd7, C_ACT, 2'd2, 13'h030);
      push_exp(1'b0, 8'd3, C_RD, 2'd2, 13'h006);
      fork
         drive_req(1'b0, 2'd2, 13'h030, 11'h006);
         ref_on_pre();
      join
      drain();
      check("open_after_miss_ref", int'(bank_open_o), 'h4);

      // Reset one cycle after an ACT abandons the access.
      push_exp(1'b0, 8'd0, C_ACT, 2'd1, 13'h111);
      req_we_i = 1'b0; req_bank_i = 2'd1; req_row_i = 13'h111; req_col_i = 11'h001;
      req_valid_i = 1'b1;
      wait_cmd(C_ACT);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      req_valid_i = 1'b0;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check_reset("reset_mid");
      repeat (12) @(negedge clk_i);

      // Final report
      check("ready_pulses", ready_cnt, 13);
      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
